// File: rtl/mext_pkg.sv
// rtl/mext_pkg.sv - shared constants, state encoding and sign helper for the RV32M sequencer
// Purpose: funct3 codes, FSM state type, corner-case operand values and the
//          funct3 -> operand-signedness mapping used by the sequencer.
// Ports:   none (package).
package mext_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  // [1] = operand A signed, [0] = operand B signed
  function automatic logic [1:0] sign_of(input logic [2:0] funct3);
    logic [1:0] s;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: s = 2'b11;
      F3_MULHSU:                       s = 2'b10;
      default:                         s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mext_special_case.sv
// rtl/mext_special_case.sv - combinational divide-by-zero / signed-overflow detect
// Purpose: flags divide/remainder ops whose architectural result is fixed by
//          the ISA and supplies that result, so the divider is never used.
// Ports:   funct3, rs1, rs2 (in)  - op being offered for accept
//          hit (out)              - op resolves without the datapath
//          result (out)           - architectural result when hit=1
module mext_special_case
  import mext_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        hit,
  output logic [31:0] result
);

  logic overflow;

  assign overflow = (rs1 == INT_MIN) && (rs2 == NEG_ONE);

  always_comb begin
    hit    = 1'b0;
    result = '0;
    // funct3[2] selects the divide family; funct3[1] picks remainder over quotient
    if (funct3[2]) begin
      if (rs2 == '0) begin
        hit    = 1'b1;
        result = funct3[1] ? rs1 : NEG_ONE;
      end else if (overflow && (funct3 == F3_DIV)) begin
        hit    = 1'b1;
        result = INT_MIN;
      end else if (overflow && (funct3 == F3_REM)) begin
        hit    = 1'b1;
        result = '0;
      end
    end
  end

endmodule

// File: rtl/mext_sequencer.sv
// rtl/mext_sequencer.sv - multi-cycle controller for the shared RV32M mul/div datapath
// Purpose: accepts one M-extension op per handshake, holds operands on the
//          datapath for a fixed latency, registers the selected result and
//          presents it until writeback takes it. Special divide cases bypass
//          the datapath; flush aborts the in-flight op.
// Ports:   clk, rst                         - clock, sync active-high reset
//          req_valid/ready, req_funct3/rs1/rs2/tag - op request handshake
//          flush                            - abort in-flight op, no response
//          resp_valid/ready, resp_data/tag  - result handshake
//          busy                             - op in EXEC or DONE
//          dp_mul_en, dp_div_en, dp_a, dp_b, dp_sign - datapath controls
//          dp_ab_msb, dp_ab_lsb, dp_quo, dp_rem      - datapath results
module mext_sequencer
  import mext_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic             dp_mul_en,
  output logic             dp_div_en,
  output logic [31:0]      dp_a,
  output logic [31:0]      dp_b,
  output logic [1:0]       dp_sign,
  input  logic [31:0]      dp_ab_msb,
  input  logic [31:0]      dp_ab_lsb,
  input  logic [31:0]      dp_quo,
  input  logic [31:0]      dp_rem
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q;
  logic [31:0]        a_q, b_q;
  logic [1:0]         sign_q;
  logic [TAG_W-1:0]   tag_q;
  logic [31:0]        data_q;

  logic               accept;
  logic               load_op;
  logic               load_result;
  logic [31:0]        result_d;
  logic [31:0]        dp_result;
  logic               sc_hit;
  logic [31:0]        sc_result;

  // Special cases are judged on the live request so they can complete on the accept edge
  mext_special_case u_special (
    .funct3 (req_funct3),
    .rs1    (req_rs1),
    .rs2    (req_rs2),
    .hit    (sc_hit),
    .result (sc_result)
  );

  always_comb begin
    dp_result = dp_rem;
    case (f3_q)
      F3_MUL:                        dp_result = dp_ab_lsb;
      F3_MULH, F3_MULHSU, F3_MULHU:  dp_result = dp_ab_msb;
      F3_DIV, F3_DIVU:               dp_result = dp_quo;
      default:                       dp_result = dp_rem;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_op     = 1'b0;
    load_result = 1'b0;
    result_d    = data_q;

    req_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && resp_ready));
    accept     = req_valid && req_ready;
    resp_valid = !flush && (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    dp_mul_en  = !flush && (state_q == ST_EXEC) && !f3_q[2];
    dp_div_en  = !flush && (state_q == ST_EXEC) &&  f3_q[2];

    case (state_q)
      ST_IDLE: ;
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          load_result = 1'b1;
          result_d    = dp_result;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new op may be taken from IDLE or while the previous result drains
    if (accept) begin
      load_op = 1'b1;
      if (sc_hit) begin
        state_d     = ST_DONE;
        load_result = 1'b1;
        result_d    = sc_result;
      end else begin
        state_d = ST_EXEC;
        cnt_d   = req_funct3[2] ? DIV_CNT : MUL_CNT;
      end
    end

    if (flush) begin
      state_d     = ST_IDLE;
      load_op     = 1'b0;
      load_result = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_op) begin
        f3_q   <= req_funct3;
        a_q    <= req_rs1;
        b_q    <= req_rs2;
        sign_q <= sign_of(req_funct3);
        tag_q  <= req_tag;
      end
      if (load_result) data_q <= result_d;
    end
  end

  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign dp_sign   = sign_q;
  assign resp_data = data_q;
  assign resp_tag  = tag_q;

endmodule

// File: tb/tb_mext_sequencer.sv
// tb/tb_mext_sequencer.sv - self-checking bench for mext_sequencer with a stub datapath
module tb_mext_sequencer;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;
  localparam int TAG_W   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic             dp_mul_en;
  logic             dp_div_en;
  logic [31:0]      dp_a;
  logic [31:0]      dp_b;
  logic [1:0]       dp_sign;
  logic [31:0]      dp_ab_msb;
  logic [31:0]      dp_ab_lsb;
  logic [31:0]      dp_quo;
  logic [31:0]      dp_rem;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mext_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .busy(busy),
    .dp_mul_en(dp_mul_en), .dp_div_en(dp_div_en),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sign(dp_sign),
    .dp_ab_msb(dp_ab_msb), .dp_ab_lsb(dp_ab_lsb), .dp_quo(dp_quo), .dp_rem(dp_rem)
  );

  // Stub datapath: extends operands per dp_sign and computes in 64 bits
  logic signed [63:0] st_a, st_b, st_p, st_q, st_r;
  always_comb begin
    st_a = dp_sign[1] ? {{32{dp_a[31]}}, dp_a} : {32'd0, dp_a};
    st_b = dp_sign[0] ? {{32{dp_b[31]}}, dp_b} : {32'd0, dp_b};
    st_p = st_a * st_b;
    st_q = '0;
    st_r = '0;
    if (dp_b != '0) begin
      st_q = st_a / st_b;
      st_r = st_a % st_b;
    end
    dp_ab_msb = st_p[63:32];
    dp_ab_lsb = st_p[31:0];
    dp_quo    = st_q[31:0];
    dp_rem    = st_r[31:0];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Architectural RV32M results straight from the ISA definition
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, r;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f3)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = (ua * ub) >>> 32;
      3'd4: r = (b == 0) ? -64'sd1 : (ovf ? 64'sh8000_0000 : sa / sb);
      3'd5: r = (b == 0) ? -64'sd1 : ua / ub;
      3'd6: r = (b == 0) ? ua : (ovf ? 64'sd0 : sa % sb);
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [1:0] ref_sign(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd1, 3'd4, 3'd6: return 2'b11;
      3'd2:                   return 2'b10;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Model: one op slot with a countdown of cycles until its result is visible
  bit               m_pending = 1'b0;
  int               m_wait    = 0;
  logic [2:0]       m_f3      = '0;
  logic [31:0]      m_a       = '0;
  logic [31:0]      m_b       = '0;
  logic [TAG_W-1:0] m_tag     = '0;

  function automatic bit exp_ready();
    return !flush && (!m_pending || (m_wait == 0 && resp_ready));
  endfunction

  always @(posedge clk) begin
    if (rst || flush) begin
      m_pending <= 1'b0;
    end else begin
      if (m_pending) begin
        if (m_wait > 0) m_wait <= m_wait - 1;
        else if (resp_ready) m_pending <= 1'b0;
      end
      if (req_valid && exp_ready()) begin
        m_pending <= 1'b1;
        m_f3      <= req_funct3;
        m_a       <= req_rs1;
        m_b       <= req_rs2;
        m_tag     <= req_tag;
        m_wait    <= ref_special(req_funct3, req_rs1, req_rs2) ? 0 :
                     (req_funct3[2] ? DIV_LAT : MUL_LAT);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit ev, ex;
      ev = m_pending && (m_wait == 0) && !flush;
      ex = m_pending && (m_wait > 0);
      check("m_req_ready", 32'(req_ready), 32'(exp_ready()));
      check("m_resp_valid", 32'(resp_valid), 32'(ev));
      check("m_busy", 32'(busy), 32'(m_pending));
      check("m_mul_en", 32'(dp_mul_en), 32'(ex && !flush && !m_f3[2]));
      check("m_div_en", 32'(dp_div_en), 32'(ex && !flush && m_f3[2]));
      if (ev) begin
        check("m_resp_data", resp_data, ref_result(m_f3, m_a, m_b));
        check("m_resp_tag", 32'(resp_tag), 32'(m_tag));
      end
      if (ex) begin
        check("m_dp_a", dp_a, m_a);
        check("m_dp_b", dp_b, m_b);
        check("m_dp_sign", 32'(dp_sign), 32'(ref_sign(m_f3)));
      end
    end
  end

  task automatic check_reset_outputs(input string tag_name);
    @(negedge clk);
    check({tag_name, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag_name, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag_name, "_busy"}, 32'(busy), 32'd0);
    check({tag_name, "_mul_en"}, 32'(dp_mul_en), 32'd0);
    check({tag_name, "_div_en"}, 32'(dp_div_en), 32'd0);
    check({tag_name, "_dp_a"}, dp_a, 32'd0);
    check({tag_name, "_dp_b"}, dp_b, 32'd0);
    check({tag_name, "_dp_sign"}, 32'(dp_sign), 32'd0);
    check({tag_name, "_resp_data"}, resp_data, 32'd0);
    check({tag_name, "_resp_tag"}, 32'(resp_tag), 32'd0);
  endtask

  // exp_lat counts negedges after the accepting edge up to the one where
  // resp_valid is first seen: 1 for special cases, LAT+1 for datapath ops.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag,
                       input logic [31:0] exp_data, input int exp_lat,
                       input int exp_en, input logic [1:0] exp_sign);
    int lat, en;
    bit got;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_tag = tag;
    @(negedge clk);
    check({name, "_accept_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_funct3 = 3'($urandom);
    req_rs1    = $urandom;
    req_rs2    = $urandom;
    req_tag    = TAG_W'($urandom);
    lat = 0; en = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (dp_mul_en || dp_div_en) begin
        en++;
        if (en == 1) check({name, "_sign"}, 32'(dp_sign), 32'(exp_sign));
      end
      if (resp_valid) got = 1'b1;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_en_cycles"}, 32'(en), 32'(exp_en));
    check({name, "_data"}, resp_data, exp_data);
    check({name, "_tag"}, 32'(resp_tag), 32'(tag));
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    check({name, "_valid_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0;
    req_tag = '0; flush = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");
    @(posedge clk); #1;

    do_op("mulh",      3'd1, 32'hFFFF_FFFE, 32'd3,        5'd1, 32'hFFFF_FFFF, 3, 2, 2'b11);
    do_op("divu",      3'd5, 32'd100,       32'd7,        5'd2, 32'd14,        5, 4, 2'b00);
    do_op("remu",      3'd7, 32'd100,       32'd7,        5'd3, 32'd2,         5, 4, 2'b00);
    do_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 1, 0, 2'b11);
    do_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'd0,         1, 0, 2'b11);
    do_op("rem_zero",  3'd6, 32'h0000_1234, 32'd0,        5'd6, 32'h0000_1234, 1, 0, 2'b11);
    do_op("divu_zero", 3'd5, 32'd55,        32'd0,        5'd7, 32'hFFFF_FFFF, 1, 0, 2'b00);
    do_op("mul",       3'd0, 32'd6,         32'd7,        5'd8, 32'd42,        3, 2, 2'b11);

    // Backpressure: hold the result, then drain and accept on the same edge
    resp_ready = 1'b0;
    req_valid = 1'b1; req_funct3 = 3'd5; req_rs1 = 32'd100; req_rs2 = 32'd7; req_tag = 5'd10;
    @(posedge clk); #1;
    req_funct3 = 3'd0; req_rs1 = 32'd6; req_rs2 = 32'd7; req_tag = 5'd11;
    wait_valid("bp_first");
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_data", resp_data, 32'd14);
      check("bp_hold_tag", 32'(resp_tag), 32'd10);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 32'(resp_valid), 32'd0);
    check("bp_next_mul_en", 32'(dp_mul_en), 32'd1);
    check("bp_next_dp_a", dp_a, 32'd6);
    wait_valid("bp_second");
    check("bp_second_data", resp_data, 32'd42);
    check("bp_second_tag", 32'(resp_tag), 32'd11);
    @(posedge clk); #1;

    // Flush two edges after accepting a DIV, with another op offered meanwhile
    req_valid = 1'b1; req_funct3 = 3'd4; req_rs1 = 32'd1000; req_rs2 = 32'hFFFF_FFFD; req_tag = 5'd12;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd3; req_rs2 = 32'd3; req_tag = 5'd13;
    @(negedge clk);
    check("flush_req_ready", 32'(req_ready), 32'd0);
    check("flush_div_en", 32'(dp_div_en), 32'd0);
    @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_en", 32'(dp_div_en | dp_mul_en), 32'd0);
      check("flush_no_resp", 32'(resp_valid), 32'd0);
    end
    @(posedge clk); #1;
    do_op("div_after_flush", 3'd4, 32'd1000, 32'hFFFF_FFFD, 5'd14, 32'hFFFF_FEB3, 5, 4, 2'b11);

    // Reset in the middle of EXEC
    req_valid = 1'b1; req_funct3 = 3'd4; req_rs1 = 32'd1000; req_rs2 = 32'd7; req_tag = 5'd15;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd16, 32'hFFFF_FFFF, 3, 2, 2'b10);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
